input_port_credit_buffer: RTL and testbench
===========================================

Name: input_port_credit_buffer

Overview:
Downstream end of the router credit-flow link: one per-port input buffer that accepts flits from the upstream router and holds them in a small FIFO. It presents the head flit and its 3-bit output-port target (1..7, 0 = no request) to the local allocator, and returns one credit to the upstream credit counter for every flit it pops. DEPTH must equal the upstream credit ceiling (4), so upstream never overruns the buffer in correct operation.

Parameters:
DATA_W, 32, flit width in bits
DEPTH, 4, FIFO entries; legal range 2..7; must match upstream credit maximum
TARG_LSB, 0, bit position of the 3-bit target field inside a flit (field = flit[TARG_LSB+2:TARG_LSB])

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
flit_in  input  DATA_W  flit from upstream router
valid_in  input  1  flit_in valid this cycle (push request)
pop  input  1  local switch consumed head flit this cycle
flit_out  output  DATA_W  head flit (first-word fall-through)
targ  output  3  target port of head flit; 0 when empty
empty  output  1  no valid entries
full  output  1  count == DEPTH
count  output  3  number of valid entries, 0..DEPTH
cred_out  output  1  credit to upstream, one pulse per accepted pop
ovf_err  output  1  sticky overflow flag

Behaviour:
- Reset (rst=1 at clk edge): rd_ptr=wr_ptr=0, count=0, cred_out=0, ovf_err=0; storage contents not reset. Consequently empty=1, full=0, targ=0, flit_out don't-care. Reset mid-operation discards all stored flits and any pending credit; no cred_out pulse follows reset.
- Effective pop: pop_eff = pop & ~empty. Pop on empty is ignored: no pointer change, no credit.
- Effective push: push_eff = valid_in & (~full | pop_eff). Push when full with a same-cycle effective pop is accepted (entry freed and refilled in the same edge).
- Overflow: valid_in & full & ~pop_eff -> flit dropped, storage/pointers/count unchanged, ovf_err set to 1 on that edge and held until rst.
- Write: on push_eff, mem[wr_ptr] <= flit_in; wr_ptr advances; wraps from DEPTH-1 to 0 (explicit compare, DEPTH need not be a power of 2).
- Read: on pop_eff, rd_ptr advances with the same wrap rule.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- flit_out = mem[rd_ptr] combinationally; a flit pushed at edge N is visible at flit_out/targ after edge N (one-cycle write-to-head latency when empty).
- targ = empty ? 3'd0 : flit_out[TARG_LSB+2:TARG_LSB], combinational. A head flit whose field is 0 presents targ=0 (no request) but can still be popped.
- empty = (count==0); full = (count==DEPTH); both combinational from registered count.
- cred_out is a register: cred_out <= pop_eff. One-cycle high pulse at edge N+1 for a pop at edge N. Back-to-back pops keep cred_out high continuously, one credit per cycle.
- Invariant for the verifier: pushes accepted - credits returned == count, with credit counted at the pop edge; upstream counter + this count stay consistent.

Test Plan:
- Reset then idle: rst=1 two cycles, release -> empty=1, full=0, count=0, targ=0, cred_out=0, ovf_err=0.
- Fill: push flits 0xA1,0xA2,0xA3,0xA4 (target fields 1,2,3,4) on consecutive cycles -> count 1,2,3,4; full=1 after the 4th; flit_out=0xA1 and targ=1 throughout.
- Overflow: with full and pop=0, push 0xA5 -> dropped, count stays 4, ovf_err=1 and stays 1; following pops return 0xA1..0xA4 in order, 0xA5 never appears.
- Full push+pop: with full, valid_in=1 flit 0xB7 (targ 7) and pop=1 in the same cycle -> count stays 4, ovf_err unchanged, cred_out=1 next cycle; 0xB7 emerges after three more pops; pointer wrap verified.
- Drain and credits: pop 4 consecutive cycles from full -> cred_out high for exactly 4 cycles, starting one cycle after first pop; then empty=1, targ=0; extra pop on empty -> no cred_out, count stays 0.
- Reset mid-operation: 3 entries held and pop=1 at the same edge that rst=1 -> count=0, empty=1, cred_out=0 the following cycle, ovf_err cleared.

Source files
------------

// File: rtl/input_port_credit_buffer.sv
// input_port_credit_buffer: per-port router input FIFO with credit return.
// Ports: clk, rst (sync, active-high); flit_in/valid_in push from upstream;
//   pop from local switch; flit_out/targ head flit and its target port
//   (0 = no request); empty/full/count occupancy; cred_out one pulse per
//   accepted pop; ovf_err sticky overflow flag.
module input_port_credit_buffer #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int TARG_LSB = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] flit_in,
  input  logic              valid_in,
  input  logic              pop,
  output logic [DATA_W-1:0] flit_out,
  output logic [2:0]        targ,
  output logic              empty,
  output logic              full,
  output logic [2:0]        count,
  output logic              cred_out,
  output logic              ovf_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [2:0]    CMAX = 3'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [2:0]        cnt;

  logic pop_eff;
  logic push_eff;
  logic ovf;

  assign empty = (cnt == 3'd0);
  assign full  = (cnt == CMAX);
  assign count = cnt;

  assign pop_eff  = pop & ~empty;
  // A full buffer still accepts a flit when the head leaves this cycle.
  assign push_eff = valid_in & (~full | pop_eff);
  assign ovf      = valid_in & full & ~pop_eff;

  assign flit_out = mem[rd_ptr];
  assign targ     = empty ? 3'd0
                          : flit_out[TARG_LSB +: 3];

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr] <= flit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      cred_out <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      // Explicit wrap so DEPTH need not be a power of two.
      if (push_eff) begin
        wr_ptr <= (wr_ptr == LAST) ? '0
                                   : wr_ptr + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr <= (rd_ptr == LAST) ? '0
                                   : rd_ptr + 1'b1;
      end
      unique case ({push_eff, pop_eff})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
      cred_out <= pop_eff;
      if (ovf) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_port_credit_buffer.sv
// tb_input_port_credit_buffer: directed checks of the input credit buffer.
// Drives inputs 1ns after each rising edge and samples there as well.
module tb_input_port_credit_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] flit_in;
  logic        valid_in;
  logic        pop;
  logic [31:0] flit_out;
  logic [2:0]  targ;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        cred_out;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_port_credit_buffer #(
    .DATA_W(32),
    .DEPTH(4),
    .TARG_LSB(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flit_in(flit_in),
    .valid_in(valid_in),
    .pop(pop),
    .flit_out(flit_out),
    .targ(targ),
    .empty(empty),
    .full(full),
    .count(count),
    .cred_out(cred_out),
    .ovf_err(ovf_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] f,
                       input logic p);
    valid_in = v;
    flit_in  = f;
    pop      = p;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_targ", 32'(targ), 0);
    chk("rst_cred", 32'(cred_out), 0);
    chk("rst_ovf", 32'(ovf_err), 0);

    // Fill with A1..A4 (targets 1..4).
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA1 + 32'(i), 1'b0);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_head", flit_out, 32'hA1);
      chk("fill_targ", 32'(targ), 1);
      chk("fill_full", 32'(full), (i == 3) ? 1 : 0);
    end

    // Overflow: A5 dropped, flag sticks.
    drive(1'b1, 32'hA5, 1'b0);
    tick();
    chk("ovf_count", 32'(count), 4);
    chk("ovf_flag", 32'(ovf_err), 1);
    chk("ovf_head", flit_out, 32'hA1);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("ovf_hold", 32'(ovf_err), 1);
    chk("ovf_cred", 32'(cred_out), 0);

    // Full push + pop: B7 enters as A1 leaves.
    drive(1'b1, 32'hB7, 1'b1);
    tick();
    chk("pp_count", 32'(count), 4);
    chk("pp_full", 32'(full), 1);
    chk("pp_cred", 32'(cred_out), 1);
    chk("pp_ovf", 32'(ovf_err), 1);
    chk("pp_head", flit_out, 32'hA2);
    chk("pp_targ", 32'(targ), 2);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("idle_cred", 32'(cred_out), 0);
    chk("idle_count", 32'(count), 4);

    // Drain four: A2 popped, then A3, A4, B7 (wrapped slot).
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("d1_cred", 32'(cred_out), 1);
    chk("d1_head", flit_out, 32'hA3);
    chk("d1_count", 32'(count), 3);
    tick();
    chk("d2_cred", 32'(cred_out), 1);
    chk("d2_head", flit_out, 32'hA4);
    chk("d2_targ", 32'(targ), 4);
    tick();
    chk("d3_cred", 32'(cred_out), 1);
    chk("d3_head", flit_out, 32'hB7);
    chk("d3_targ", 32'(targ), 7);
    chk("d3_count", 32'(count), 1);
    tick();
    chk("d4_cred", 32'(cred_out), 1);
    chk("d4_empty", 32'(empty), 1);
    chk("d4_targ", 32'(targ), 0);
    chk("d4_count", 32'(count), 0);
    // Pop on empty is ignored.
    tick();
    chk("pe_cred", 32'(cred_out), 0);
    chk("pe_count", 32'(count), 0);
    chk("pe_empty", 32'(empty), 1);

    // Latency and zero-target head.
    drive(1'b1, 32'hD6, 1'b0);
    tick();
    chk("lat_count", 32'(count), 1);
    chk("lat_head", flit_out, 32'hD6);
    chk("lat_targ", 32'(targ), 6);
    drive(1'b1, 32'hE8, 1'b0);
    tick();
    // Push + pop while partially full keeps count.
    drive(1'b1, 32'hC1, 1'b1);
    tick();
    chk("pp2_count", 32'(count), 2);
    chk("pp2_head", flit_out, 32'hE8);
    chk("t0_targ", 32'(targ), 0);
    chk("t0_empty", 32'(empty), 0);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("t0_pop_cnt", 32'(count), 1);
    chk("t0_pop_cred", 32'(cred_out), 1);
    chk("c1_head", flit_out, 32'hC1);

    // Build 3 entries, then reset while popping.
    drive(1'b1, 32'hC2, 1'b0);
    tick();
    drive(1'b1, 32'hC3, 1'b0);
    tick();
    chk("mr_count", 32'(count), 3);
    drive(1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    tick();
    chk("mr_count0", 32'(count), 0);
    chk("mr_empty", 32'(empty), 1);
    chk("mr_cred", 32'(cred_out), 0);
    chk("mr_ovf", 32'(ovf_err), 0);
    chk("mr_targ", 32'(targ), 0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("mr_cred2", 32'(cred_out), 0);
    chk("mr_count2", 32'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
